// File: rtl/pipe_pkg.sv
// Stage-control types shared by the pipeline registers, with the flush/stall priority decode.
`include "defines.svh"

package pipe_pkg;

    localparam int STALL_MAX = 32;

    typedef enum logic [1:0] {
        CTRL_FLUSH,
        CTRL_BUBBLE,
        CTRL_ADVANCE,
        CTRL_HOLD
    } stage_ctrl_e;

    // A stage emits a bubble only when it is stopped and its downstream neighbour is moving.
    function automatic stage_ctrl_e get_stage_ctrl(input logic [STALL_MAX-1:0] stall,
                                                   input logic flush,
                                                   input int stage);
        stage_ctrl_e ctrl;
        if (flush) begin
            ctrl = CTRL_FLUSH;
        end else if (stall[stage] == `STOP && stall[stage+1] == `NO_STOP) begin
            ctrl = CTRL_BUBBLE;
        end else if (stall[stage] == `NO_STOP) begin
            ctrl = CTRL_ADVANCE;
        end else begin
            ctrl = CTRL_HOLD;
        end
        return ctrl;
    endfunction

endpackage

// File: rtl/defines.svh
// Shared pipeline encodings: stall polarity, reset level and the NOP register write.
`ifndef DEFINES_SVH
`define DEFINES_SVH

`define STOP          1'b1
`define NO_STOP       1'b0
`define RST_ENABLE    1'b0
`define NOP_REG_ADDR  5'b00000
`define WRITE_DISABLE 1'b0

`endif

// File: rtl/stage_ctrl_dec.sv
// Combinational decode of flush and the stall vector into this stage's control action.
`include "defines.svh"

module stage_ctrl_dec
    import pipe_pkg::*;
#(
    parameter int STALL_W = 6,
    parameter int STAGE   = 3
) (
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    output stage_ctrl_e        ctrl
);

    logic [STALL_MAX-1:0] stall_ext;

    always_comb begin
        stall_ext = '0;
        stall_ext[STALL_W-1:0] = stall;
    end

    assign ctrl = get_stage_ctrl(stall_ext, flush, STAGE);

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with N_CH masked write channels and the multi-cycle loopback.
// Define EX_MEM_PERF_EN to add saturating hold/bubble cycle counters.
`include "defines.svh"

module ex_mem_pipe
    import pipe_pkg::*;
#(
    parameter int N_DATA  = 32,
    parameter int N_ADDR  = 5,
    parameter int N_CH    = 2,
    parameter int N_TEMP  = 64,
    parameter int N_CNT   = 2,
    parameter int STALL_W = 6,
    parameter int STAGE   = 3
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [STALL_W-1:0]       i_stall,
    input  logic                     i_flush,
    input  logic                     i_valid,
    input  logic [N_CH-1:0]          i_wen,
    input  logic [N_CH*N_ADDR-1:0]   i_waddr,
    input  logic [N_CH*N_DATA-1:0]   i_wdata,
    output logic                     o_valid,
    output logic [N_CH-1:0]          o_wen,
    output logic [N_CH*N_ADDR-1:0]   o_waddr,
    output logic [N_CH*N_DATA-1:0]   o_wdata,
    input  logic [N_TEMP-1:0]        i_temp,
    input  logic [N_CNT-1:0]         i_cnt,
    output logic [N_TEMP-1:0]        o_temp,
`ifdef EX_MEM_PERF_EN
    output logic [N_CNT-1:0]         o_cnt,
    output logic [31:0]              o_stall_cycles,
    output logic [31:0]              o_bubble_cycles
`else
    output logic [N_CNT-1:0]         o_cnt
`endif
);

    if (STAGE + 1 >= STALL_W || N_CH < 1) begin : g_param_check
        $error("ex_mem_pipe: STAGE+1 must be below STALL_W and N_CH must be at least 1");
    end

    localparam logic [N_CH*N_ADDR-1:0] NOP_ADDRS = {N_CH{N_ADDR'(`NOP_REG_ADDR)}};
    localparam logic [N_CH-1:0]        NO_WRITES = {N_CH{`WRITE_DISABLE}};

    stage_ctrl_e ctrl;

    stage_ctrl_dec #(
        .STALL_W (STALL_W),
        .STAGE   (STAGE)
    ) u_ctrl (
        .stall (i_stall),
        .flush (i_flush),
        .ctrl  (ctrl)
    );

    logic [N_CH-1:0]        adv_wen;
    logic [N_CH*N_ADDR-1:0] adv_waddr;
    logic [N_CH*N_DATA-1:0] adv_wdata;

    // A channel disabled (or carried by an invalid slot) turns into a clean NOP write.
    always_comb begin
        adv_wen   = NO_WRITES;
        adv_waddr = NOP_ADDRS;
        adv_wdata = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (i_wen[k] & i_valid) begin
                adv_wen[k]                    = 1'b1;
                adv_waddr[k*N_ADDR +: N_ADDR] = i_waddr[k*N_ADDR +: N_ADDR];
                adv_wdata[k*N_DATA +: N_DATA] = i_wdata[k*N_DATA +: N_DATA];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (i_rst_n == `RST_ENABLE) begin
            o_valid <= 1'b0;
            o_wen   <= NO_WRITES;
            o_waddr <= NOP_ADDRS;
            o_wdata <= '0;
            o_temp  <= '0;
            o_cnt   <= '0;
        end else begin
            case (ctrl)
                CTRL_FLUSH: begin
                    o_valid <= 1'b0;
                    o_wen   <= NO_WRITES;
                    o_waddr <= NOP_ADDRS;
                    o_wdata <= '0;
                    o_temp  <= '0;
                    o_cnt   <= '0;
                end
                CTRL_BUBBLE: begin
                    o_valid <= 1'b0;
                    o_wen   <= NO_WRITES;
                    o_waddr <= NOP_ADDRS;
                    o_wdata <= '0;
                    o_temp  <= i_temp;
                    o_cnt   <= i_cnt;
                end
                CTRL_ADVANCE: begin
                    o_valid <= i_valid;
                    o_wen   <= adv_wen;
                    o_waddr <= adv_waddr;
                    o_wdata <= adv_wdata;
                    o_temp  <= '0;
                    o_cnt   <= '0;
                end
                default: begin
                    o_temp  <= i_temp;
                    o_cnt   <= i_cnt;
                end
            endcase
        end
    end

`ifdef EX_MEM_PERF_EN
    // Counters survive flushes on purpose so stall statistics span exception recovery.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (i_rst_n == `RST_ENABLE) begin
            o_stall_cycles  <= '0;
            o_bubble_cycles <= '0;
        end else begin
            if (ctrl == CTRL_HOLD && o_stall_cycles != 32'hFFFF_FFFF) begin
                o_stall_cycles <= o_stall_cycles + 32'd1;
            end
            if (ctrl == CTRL_BUBBLE && o_bubble_cycles != 32'hFFFF_FFFF) begin
                o_bubble_cycles <= o_bubble_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
